// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C request arbiter and its sub-blocks.
//   I2C_ADDR_W  : width of a 7-bit I2C slave address
//   I2C_DATA_W  : width of one write byte
//   TMO_CNT_W   : width of the transaction watchdog counter
//   arb_state_t : arbiter FSM states
//   tmo_cnt_t   : watchdog counter type
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int TMO_CNT_W  = 8;

  typedef logic [TMO_CNT_W-1:0] tmo_cnt_t;

  // IDLE     : waiting for any request
  // LAUNCH   : one-cycle start strobe to the master
  // WAIT     : master running, watchdog counting
  // COMPLETE : ack pulse to the grantee
  // DRAIN    : timed out, waiting for the master to release busy
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT     = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_DRAIN    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Starting one position after the
// pointer (wrapping modulo NUM_REQ), returns the first requester whose
// request bit is set.
// Ports:
//   i_req    [NUM_REQ-1:0] : request level per requester
//   i_ptr    [IDX_W-1:0]   : index of the last served requester
//   o_winner [IDX_W-1:0]   : selected requester (0 when none found)
//   o_found                : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_found
);

  logic [IDX_W-1:0] w_idx;

  // NOTE: every variable of a combinational block gets a default on entry,
  // otherwise paths that skip an assignment would infer a latch.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    // Walk from the farthest candidate towards the nearest; the nearest set
    // bit after the pointer is therefore the last one written and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_req_arbiter
// Shares one i2c_master between NUM_REQ requesters issuing single-byte
// writes. Pending requests are granted round-robin; the granted address and
// data are registered and held until the next grant, because the master
// samples them late in its transfer. A watchdog aborts a transaction whose
// done pulse never arrives and, if the master is still busy, waits for it to
// go idle before granting again.
//
// Parameters:
//   NUM_REQ        : number of requesters, 2..8
//   TIMEOUT_CYCLES : cycles allowed from m_start to m_done, 1..255
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   req          [NUM_REQ]     : request level per requester
//   req_addr     [NUM_REQ*7]   : slave address, requester i at [7i+6:7i]
//   req_data     [NUM_REQ*8]   : write byte, requester i at [8i+7:8i]
//   req_ack      [NUM_REQ]     : one-cycle completion pulse (one-hot)
//   req_err      [NUM_REQ]     : one-cycle timeout pulse (one-hot)
//   m_start                    : start strobe to the master
//   m_slave_addr [7]           : address to the master
//   m_data       [8]           : data to the master
//   m_busy                     : master busy
//   m_done                     : master done (one-cycle pulse)
//   grant_id     [clog2(NUM_REQ)] : current or last grantee
//   arb_busy                   : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           req_err,
  output logic                         m_start,
  output logic [I2C_ADDR_W-1:0]        m_slave_addr,
  output logic [I2C_DATA_W-1:0]        m_data,
  input  logic                         m_busy,
  input  logic                         m_done,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         arb_busy
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  arb_state_t              r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_grant_id;
  logic [I2C_ADDR_W-1:0]   r_addr;
  logic [I2C_DATA_W-1:0]   r_data;
  tmo_cnt_t                r_cnt;
  logic                    r_m_start;
  logic                    r_arb_busy;
  logic [NUM_REQ-1:0]      r_req_ack;
  logic [NUM_REQ-1:0]      r_req_err;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]        w_winner;
  logic                    w_found;
  logic [I2C_ADDR_W-1:0]   w_sel_addr;
  logic [I2C_DATA_W-1:0]   w_sel_data;
  tmo_cnt_t                w_cnt_next;
  logic                    w_timeout;
  logic [NUM_REQ-1:0]      w_grant_onehot;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  assign w_sel_addr     = req_addr[w_winner*I2C_ADDR_W +: I2C_ADDR_W];
  assign w_sel_data     = req_data[w_winner*I2C_DATA_W +: I2C_DATA_W];

  // The counter is cleared in LAUNCH and advanced on every WAIT cycle, so the
  // incremented value equals the number of WAIT cycles seen so far. Comparing
  // the incremented value puts the err pulse TIMEOUT_CYCLES+1 cycles after
  // m_start.
  assign w_cnt_next     = r_cnt + tmo_cnt_t'(1);
  assign w_timeout      = (w_cnt_next == tmo_cnt_t'(TIMEOUT_CYCLES));
  assign w_grant_onehot = NUM_REQ'(1) << r_grant_id;

  // ---------------------------------------------------------------------------
  // FSM, grant registers and watchdog
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_W'(NUM_REQ - 1);  // requester 0 is searched first
      r_grant_id <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_m_start  <= 1'b0;
      r_arb_busy <= 1'b0;
      r_req_ack  <= '0;
      r_req_err  <= '0;
    end else begin
      // Strobes are single-cycle; only the states that fire them set them.
      r_m_start <= 1'b0;
      r_req_ack <= '0;
      r_req_err <= '0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_winner;
            r_addr     <= w_sel_addr;
            r_data     <= w_sel_data;
            r_m_start  <= 1'b1;
            r_arb_busy <= 1'b1;
            r_state    <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          r_cnt <= w_cnt_next;
          // A done pulse coinciding with the timeout still counts as success.
          if (m_done) begin
            r_req_ack <= w_grant_onehot;
            r_state   <= ST_COMPLETE;
          end else if (w_timeout) begin
            r_req_err <= w_grant_onehot;
            r_ptr     <= r_grant_id;
            if (m_busy) begin
              r_state <= ST_DRAIN;
            end else begin
              r_arb_busy <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end

        ST_COMPLETE: begin
          r_ptr      <= r_grant_id;
          r_arb_busy <= 1'b0;
          r_state    <= ST_IDLE;
        end

        ST_DRAIN: begin
          // A late done from the abandoned transfer is deliberately ignored.
          if (!m_busy) begin
            r_arb_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_arb_busy <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are driven straight from registers
  // ---------------------------------------------------------------------------
  assign m_start      = r_m_start;
  assign m_slave_addr = r_addr;
  assign m_data       = r_data;
  assign grant_id     = r_grant_id;
  assign arb_busy     = r_arb_busy;
  assign req_ack      = r_req_ack;
  assign req_err      = r_req_err;

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Shares one `i2c_master` between up to `NUM_REQ` on-chip requesters, such as the sensor poller, motor-driver configuration and LED driver, each of which issues single-byte write transactions. Pending requests are granted round-robin. The block sequences the master's `start`/`busy`/`done` handshake and holds the address and data stable for the whole transaction. A watchdog recovers from a master that never completes. It sits between the requester blocks and the single `i2c_master` instance driving the board SCL/SDA pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 255: clk cycles allowed from `m_start` to `m_done`. The counter is 8 bits wide; valid range 1..255.
- `clk` in 1: single clock for the block and the master.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in `NUM_REQ`: request level per requester.
- `req_addr` in `NUM_REQ*7`: 7-bit slave address per requester, requester i at bits `[7i+6:7i]`.
- `req_data` in `NUM_REQ*8`: write byte per requester, requester i at bits `[8i+7:8i]`.
- `req_ack` out `NUM_REQ`: one-cycle completion pulse, one-hot.
- `req_err` out `NUM_REQ`: one-cycle timeout pulse, one-hot.
- `m_start` out 1: start strobe to the master.
- `m_slave_addr` out 7: address to the master.
- `m_data` out 8: data to the master.
- `m_busy` in 1: master `busy`.
- `m_done` in 1: master `done`, a one-cycle pulse.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last grantee.
- `arb_busy` out 1: high in every state except IDLE.

## Operation
- Requester contract:
  - Raise `req` with `req_addr`/`req_data` already valid.
  - Hold all three until `req_ack` or `req_err` for that requester.
  - Dropping `req` early does not abort an issued transaction; the ack or err pulse still occurs.
- FSM states: IDLE, LAUNCH, WAIT, COMPLETE, DRAIN.
  - IDLE: if any `req` bit is set, pick the winner and register `grant_id`, `m_slave_addr` and `m_data` from its slice, then go to LAUNCH.
  - LAUNCH: `m_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: increment the counter each cycle.
    - `m_done`=1: go to COMPLETE.
    - Else counter == `TIMEOUT_CYCLES`: pulse `req_err[grant_id]`, then go to DRAIN if `m_busy`=1, otherwise to IDLE.
    - If `m_done` and the timeout occur in the same cycle, `m_done` wins.
  - COMPLETE: pulse `req_ack[grant_id]`; advance the pointer to `grant_id`; go to IDLE.
  - DRAIN: wait for `m_busy`=0, then go to IDLE. A late `m_done` seen here is ignored, with no ack.
- Arbitration is round-robin.
  - The search starts at `(ptr+1) mod NUM_REQ` and takes the first set `req` bit.
  - `ptr` updates in COMPLETE and on timeout only.
- `m_slave_addr`/`m_data` are registered at grant and held constant until the next grant. This is required because the master samples data late, at its ACK1 phase.
- Reset values:
  - `m_start`, `arb_busy`, `req_ack`, `req_err` = 0.
  - `m_slave_addr`, `m_data`, `grant_id` = 0.
  - `ptr` = `NUM_REQ-1`, so requester 0 wins first.
  - FSM = IDLE.
- Reset mid-transaction returns to IDLE immediately. No ack or err is produced for the aborted request.

## Timing
- Latency from `req` to `m_start`:
  - With `req` sampled high in IDLE at cycle N, `m_start`=1 in cycle N+1.
  - `arb_busy` is high from N+1.
- `m_done` seen in cycle D gives `req_ack` in cycle D+1. The next grant can be decided at D+2, so the earliest next `m_start` is at D+3.
- With the current master (about 22 cycles from `start` to `done`), one arbitrated write costs about 25 cycles.
- Without `m_done`, the `req_err` pulse appears `TIMEOUT_CYCLES`+1 cycles after `m_start`.
- `req_ack` and `req_err` are never high in the same cycle. At most one bit of either vector is high at a time.

## Structure
- Shared package `i2c_pkg` holds:
  - `I2C_ADDR_W`=7 and `I2C_DATA_W`=8.
  - The FSM state enum `arb_state_t`.
  - The timeout counter width.
- Sub-module `rr_picker`: combinational round-robin selection from `req` and `ptr`, giving a winner index and a `found` flag. The top level contains the FSM, registers and watchdog.

## Test plan
- Single request: after reset, `req`=0001 with addr 0x48 and data 0xA5 → `m_start` one cycle later; `m_slave_addr`=0x48 and `m_data`=0xA5 held until `done`; `req_ack`=0001 the cycle after `m_done`.
- Fairness: `req`=1111 held continuously with the real master → grant order 0,1,2,3,0; exactly one ack per requester per round.
- Timeout: stub master holds `busy` and never pulses `done`, `TIMEOUT_CYCLES`=10 → `req_err[grant]` pulses 11 cycles after `m_start`; FSM stays in DRAIN until `busy` falls; no ack is produced.
- Simultaneous event: `m_done` in the same cycle the counter reaches `TIMEOUT_CYCLES` → `req_ack` pulses and `req_err` does not.
- Early drop: requester 2 drops `req` two cycles after its grant → the transaction completes and `req_ack`=0100 still pulses; requester 2 is not re-granted.
- Reset mid-WAIT: assert `rst` 5 cycles after `m_start` → all outputs return to their reset values asynchronously; after release, requester 0 is granted first.
